// File: rtl/sdram_write.sv
// SDRAM write sub-FSM: streams a ROW_END x COL_END frame of 4-word
// bursts from a FIFO into bank 0, yielding at bursts for refresh.
module sdram_write #(
  parameter int COL_END  = 256,
  parameter int ROW_END  = 2,
  parameter int TRCD_CYC = 2,
  parameter int TWR_CYC  = 2,
  parameter int TRP_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_trig,
  input  logic        wr_en,
  input  logic        aref_req,
  output logic        wr_req,
  output logic        flag_wr_end,
  output logic [3:0]  wr_cmd,
  output logic [12:0] wr_addr,
  output logic        wr_dq_oe,
  output logic        wr_fifo_rd,
  input  logic [15:0] wr_fifo_q,
  output logic [15:0] wr_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ACT  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_PRE  = 3'd4;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PALL = 4'b0010;

  localparam logic [12:0] A10 = 13'h0400;

  localparam int PRE_LEN = TWR_CYC + TRP_CYC;
  localparam int CW = $clog2(PRE_LEN + TRCD_CYC + 1);
  localparam logic [CW-1:0] ACT_LAST = CW'(TRCD_CYC - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PALL_AT  = CW'(TWR_CYC);

  logic [2:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    burst_cnt, burst_nx;
  logic [7:0]    col_cnt, col_nx;
  logic [12:0]   row_cnt, row_nx;
  logic          row_end, frame_end;
  logic [3:0]    cmd_nx;
  logic [12:0]   addr_nx;
  logic          flag_nx;

  assign row_end   = col_cnt == 8'(COL_END - 1);
  assign frame_end = row_end && (row_cnt == 13'(ROW_END - 1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    burst_nx = burst_cnt;
    col_nx   = col_cnt;
    row_nx   = row_cnt;
    unique case (1'b1)
      state == S_IDLE: begin
        if (wr_trig) state_nx = S_REQ;
      end
      state == S_REQ: begin
        if (wr_en) begin
          state_nx = S_ACT;
          cnt_nx   = '0;
        end
      end
      state == S_ACT: begin
        if (cnt == ACT_LAST) begin
          state_nx = S_WR;
          cnt_nx   = '0;
          burst_nx = 2'd0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      state == S_WR: begin
        burst_nx = burst_cnt + 2'd1;
        if (burst_cnt == 2'd3) begin
          col_nx = row_end ? 8'd0 : col_cnt + 8'd1;
          if (row_end) row_nx = frame_end ? 13'd0 : row_cnt + 13'd1;
          if (aref_req || row_end) begin
            state_nx = S_PRE;
            cnt_nx   = '0;
          end
        end
      end
      state == S_PRE: begin
        if (cnt == PRE_LAST) begin
          cnt_nx = '0;
          // flag_wr_end already records whether the bus is being released
          if (!flag_wr_end) state_nx = S_ACT;
          else if (col_cnt == 8'd0 && row_cnt == 13'd0) state_nx = S_IDLE;
          else state_nx = S_REQ;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_nx  = CMD_NOP;
    addr_nx = A10;
    unique case (1'b1)
      state_nx == S_ACT && cnt_nx == '0: begin
        cmd_nx  = CMD_ACT;
        addr_nx = row_nx;
      end
      state_nx == S_WR: begin
        cmd_nx  = (burst_nx == 2'd0) ? CMD_WR : CMD_NOP;
        addr_nx = {3'b000, col_nx, burst_nx};
      end
      state_nx == S_PRE && cnt_nx == PALL_AT: begin
        cmd_nx = CMD_PALL;
      end
      default: ;
    endcase
  end

  assign flag_nx = (state_nx == S_PRE) && (cnt_nx == PRE_LAST) &&
                   ((col_nx == 8'd0 && row_nx == 13'd0) || aref_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      burst_cnt   <= 2'd0;
      col_cnt     <= 8'd0;
      row_cnt     <= 13'd0;
      wr_cmd      <= CMD_NOP;
      wr_addr     <= A10;
      wr_dq_oe    <= 1'b0;
      flag_wr_end <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      burst_cnt   <= burst_nx;
      col_cnt     <= col_nx;
      row_cnt     <= row_nx;
      wr_cmd      <= cmd_nx;
      wr_addr     <= addr_nx;
      wr_dq_oe    <= state_nx == S_WR;
      flag_wr_end <= flag_nx;
    end
  end

  assign wr_req     = state_nx == S_REQ;
  assign wr_fifo_rd = state_nx == S_WR;
  assign wr_data    = wr_dq_oe ? wr_fifo_q : 16'h0000;

endmodule
